avalon_ram: RTL and testbench
=============================

Name: avalon_ram

Overview:
- Word-organised 256-byte memory acting as the Avalon memory-mapped slave for the top-level MIPS CPU in simulation benches.
- Provides a bus port for CPU instruction and data accesses, with one wait state per access.
- Provides a side-band loader port through which a bench preloads program words before or while the CPU starts.
- Contents are cleared by reset, so unloaded words read as 0x00000000, which the CPU decodes as a nop.

Parameters:
- ADDR_BITS, 8, byte-address bits decoded; memory holds 2^(ADDR_BITS-2) 32-bit words (64 by default).

Ports:
- clk  input  1  single system clock, rising-edge active.
- RAM_Reset  input  1  reset, asynchronous and active-high.
- address  input  32  byte address from the CPU; only bits [ADDR_BITS-1:2] are decoded.
- write  input  1  bus write request.
- read  input  1  bus read request.
- waitrequest  output  1  slave stall; the transfer completes in the cycle where it is low.
- writedata  input  32  write data; byte lane i is bits [8i+7:8i].
- byteenable  input  4  per-lane write enables.
- readdata  output  32  read data.
- instruction  input  32  loader data word.
- inst_input  input  1  loader enable.
- inst_addr  input  8  loader byte address; bits [7:2] select the word.

Behaviour:
- Storage: mem[0..63], 32 bits per word.
  - Word index is address[ADDR_BITS-1:2]. Upper address bits are ignored, so 0xBFC00000 aliases to word 0.
  - address[1:0] are ignored.
- Reset, asynchronous on RAM_Reset high:
  - all words are cleared to 0 and the pending flag is cleared;
  - waitrequest=0 and readdata=0 while reset is held;
  - loader and bus activity are ignored during reset.
- Loader:
  - While inst_input=1 and RAM_Reset=0, mem[inst_addr[7:2]] <= instruction. This is level-sensitive and not clock-qualified.
  - A new word is captured whenever inst_addr or instruction changes, even several times between clock edges.
  - The loader has priority over a bus write to the same word.
- Handshake, via an internal pending flag:
  - waitrequest = (read | write) & ~pending & ~RAM_Reset.
  - At each rising edge, pending <= (read | write) & ~pending.
  - Every access therefore costs exactly 2 cycles: one stall cycle, then one completion cycle.
  - If the request is dropped while waitrequest=1, the access is abandoned and pending returns to 0.
- Write:
  - Committed at the rising edge where write=1 and waitrequest=0.
  - Only lanes with byteenable[i]=1 are updated; the other lanes keep their old value.
  - byteenable=0000 leaves the word unchanged but still completes the handshake.
- Read:
  - When read=1 and waitrequest=0, readdata = mem[word index], combinational, with the word returned exactly as stored (no byte swap).
  - Otherwise readdata = 0.
  - byteenable is ignored for reads.
- Simultaneous read and write: the write is performed; readdata shows the pre-write contents during the completion cycle.
- Reset asserted mid-transaction: the access is aborted with no memory update, and pending is cleared immediately.
- No other outputs exist; the block has no internal FSM beyond the pending flag.

Test Plan:
- Reset clear: pulse RAM_Reset, then read address 0x00000000 → waitrequest=1 for 1 cycle, then readdata=0x00000000.
- Loader then bus read:
  - Stimulus: inst_input=1, load 0x04←0x24030FF0, 0x08←0x386200FF, 0x0C←0x00000008, each held 1 time unit between clock edges; then drop inst_input.
  - Response: reads of 0x04, 0x08 and 0x0C return the same three words, each after one wait cycle.
- Aliasing: a read of 0xBFC00008 returns 0x386200FF, the same as address 0x08.
- Byte enables: write 0xAABBCCDD with byteenable=0011 to a word holding 0x11223344 → read returns 0x1122CCDD. Repeat with byteenable=0000 → still 0x1122CCDD.
- Handshake timing: hold read=1 for 4 cycles → waitrequest pattern is 1,0,1,0. Drop read during a wait cycle → no completion, and the next request stalls again.
- Reset mid-write: assert RAM_Reset during the write wait cycle → waitrequest drops immediately, and after reset the word reads 0.

Source files
------------

// File: rtl/avalon_ram.sv
// Word-organised RAM acting as the Avalon-MM slave of the MIPS CPU in simulation,
// with one wait state per bus access and a level-sensitive side-band program loader.
module avalon_ram #(
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        RAM_Reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  input  logic [31:0] instruction,
  input  logic        inst_input,
  input  logic [7:0]  inst_addr
);

  localparam int IW    = ADDR_BITS - 2;
  localparam int WORDS = 1 << IW;

  logic [31:0]   mem [WORDS];
  logic          pending;
  logic          req;
  logic          ld_hit;
  logic [IW-1:0] bus_idx;
  logic [IW-1:0] ld_idx;
  logic [31:0]   merge_word;

  // Bus writes are merged at the completion edge and applied through the
  // storage latch in the following cycle, so a loader update and a bus write
  // share one storage element.
  logic          wr_en_q;
  logic [IW-1:0] wr_idx_q;
  logic [31:0]   wr_word_q;

  logic          unused_bits;
  assign unused_bits = ^{address[31:ADDR_BITS], address[1:0], inst_addr[1:0]};

  assign bus_idx = address[ADDR_BITS-1:2];
  assign ld_idx  = IW'(inst_addr[7:2]);
  assign req     = read | write;
  assign ld_hit  = inst_input & (ld_idx == bus_idx);

  // Handshake: a request (read or write) is stalled with waitrequest=1 for one
  // cycle while pending=0; the following cycle (pending=1) is the completion
  // cycle with waitrequest=0. Dropping the request during the stall abandons it.
  assign waitrequest = req & ~pending & ~RAM_Reset;
  assign readdata    = (read & pending & ~RAM_Reset) ? mem[bus_idx] : 32'h0;

  always_comb begin
    merge_word = mem[bus_idx];
    for (int i = 0; i < 4; i++) begin
      if (byteenable[i]) merge_word[8*i +: 8] = writedata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge RAM_Reset) begin
    if (RAM_Reset) begin
      pending   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_word_q <= 32'h0;
    end else begin
      pending   <= req & ~pending;
      // A loader write to the same word at the completion edge wins.
      wr_en_q   <= write & pending & ~ld_hit;
      wr_idx_q  <= bus_idx;
      wr_word_q <= merge_word;
    end
  end

  // Storage is level-sensitive: the loader is not clock-qualified and must
  // capture every change of inst_addr/instruction between clock edges.
  always_latch begin
    if (RAM_Reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
    end else begin
      if (wr_en_q) mem[wr_idx_q] = wr_word_q;
      if (inst_input) mem[ld_idx] = instruction;
    end
  end

endmodule

// File: tb/tb_avalon_ram.sv
// Directed bench for avalon_ram: vector table of bus accesses plus hand-written
// sequences for loader timing, handshake timing, abandon and reset corners.
module tb_avalon_ram;

  logic        clk;
  logic        RAM_Reset;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic [31:0] instruction;
  logic        inst_input;
  logic [7:0]  inst_addr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [19];

  avalon_ram #(.ADDR_BITS(8)) dut (
    .clk         (clk),
    .RAM_Reset   (RAM_Reset),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata),
    .instruction (instruction),
    .inst_input  (inst_input),
    .inst_addr   (inst_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full bus transfer: stall cycle, completion cycle, then release.
  task automatic bus_access(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [31:0] exp);
    @(negedge clk);
    read = rd; write = wr; address = addr; writedata = wdata; byteenable = be;
    #1 check($sformatf("%s stall", tag), 32'(waitrequest), 32'd1);
    check($sformatf("%s stall_rdata", tag), readdata, 32'h0);
    @(negedge clk);
    #1 check($sformatf("%s done", tag), 32'(waitrequest), 32'd0);
    check($sformatf("%s rdata", tag), readdata, exp);
    @(posedge clk);
    #1 read = 1'b0; write = 1'b0;
  endtask

  initial begin
    logic [3:0] wait_pat;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 32'h2403_0FF0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h3862_00FF};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_000C, 32'h0, 4'h0, 32'h0000_0008};
    vecs[3]  = '{1'b1, 1'b0, 32'hBFC0_0008, 32'h0, 4'h0, 32'h3862_00FF};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_000F, 32'h0, 4'hF, 32'h0000_0008};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h1122_3344};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'h3, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h1122_CCDD};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'h0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h1122_CCDD};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0014, 32'hAABB_CCDD, 4'hC, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'hAABB_0000};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_0010, 32'h5566_7788, 4'hF, 32'h1122_CCDD};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h5566_7788};
    vecs[17] = '{1'b0, 1'b1, 32'h0000_00FC, 32'h1234_5678, 4'hA, 32'h0};
    vecs[18] = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0, 4'h0, 32'h1200_5600};

    // reset state, with a read request held during reset
    RAM_Reset = 1'b1; read = 1'b1; write = 1'b0; address = 32'h0;
    writedata = 32'h0; byteenable = 4'h0;
    instruction = 32'h0; inst_input = 1'b0; inst_addr = 8'h0;
    #2 check("reset wait", 32'(waitrequest), 32'd0);
    check("reset rdata", readdata, 32'h0);
    read = 1'b0;
    @(negedge clk);
    #1 RAM_Reset = 1'b0;
    bus_access("reset_clear", 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);

    // loader: each word held one time unit between clock edges
    @(posedge clk);
    #1 inst_input = 1'b1; inst_addr = 8'h04; instruction = 32'h2403_0FF0;
    #1 inst_addr = 8'h08; instruction = 32'h3862_00FF;
    #1 inst_addr = 8'h0C; instruction = 32'h0000_0008;
    #1 inst_input = 1'b0;

    for (int i = 0; i < 19; i++) begin
      bus_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                 vecs[i].wdata, vecs[i].be, vecs[i].exp);
    end

    // read held for 4 cycles: waitrequest 1,0,1,0
    wait_pat = 4'b0101;
    @(negedge clk);
    address = 32'h4; read = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 check($sformatf("hold%0d wait", c), 32'(waitrequest), 32'(wait_pat[c]));
      check($sformatf("hold%0d rdata", c), readdata, wait_pat[c] ? 32'h0 : 32'h2403_0FF0);
      @(negedge clk);
    end
    read = 1'b0;

    // write dropped during its stall cycle is abandoned
    @(negedge clk);
    address = 32'h10; writedata = 32'h0; byteenable = 4'hF; write = 1'b1;
    #1 check("abandon stall", 32'(waitrequest), 32'd1);
    #2 write = 1'b0;
    bus_access("abandon_reread", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h5566_7788);

    // loader holding the same word across the write completion edge wins
    @(negedge clk);
    address = 32'h20; writedata = 32'h1111_1111; byteenable = 4'hF; write = 1'b1;
    inst_input = 1'b1; inst_addr = 8'h20; instruction = 32'hCAFE_F00D;
    @(negedge clk);
    #1 check("prio done", 32'(waitrequest), 32'd0);
    @(posedge clk);
    #1 write = 1'b0;
    @(posedge clk);
    #1 inst_input = 1'b0;
    bus_access("prio_read", 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D);

    // reset asserted during the write stall cycle
    @(negedge clk);
    address = 32'h4; writedata = 32'hFFFF_FFFF; byteenable = 4'hF; write = 1'b1;
    #1 check("rstmid stall", 32'(waitrequest), 32'd1);
    #1 RAM_Reset = 1'b1;
    #1 check("rstmid wait", 32'(waitrequest), 32'd0);
    check("rstmid rdata", readdata, 32'h0);
    @(negedge clk);
    write = 1'b0;
    #1 RAM_Reset = 1'b0;
    bus_access("rstmid_word", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h0);
    bus_access("rstmid_other", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
